st_timing_adapter_ps: RTL and testbench
=======================================

ST_TIMING_ADAPTER_PS -- requirements
Module: st_timing_adapter_ps

Interface
REQ-001 SHALL have parameter DATA_W, 32, in_data/out_data width in bits.
REQ-002 SHALL have parameter ERR_W, 6, error sideband width; legal range 1..16.
REQ-003 SHALL have parameter EMPTY_W, 2, empty sideband width; legal range 1..8.
REQ-004 SHALL have parameter DEPTH, 8, FIFO entries; power of two, 2..256.
REQ-005 SHALL have parameter IN_READY_LATENCY, 3, input ready latency L; legal range 0..3, DEPTH >= L+2.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-007 SHALL have ports: in_ready out 1; in_valid in 1; in_data in DATA_W; in_error in ERR_W; in_startofpacket in 1; in_endofpacket in 1; in_empty in EMPTY_W.
REQ-008 SHALL have ports: out_ready in 1; out_valid out 1; out_data out DATA_W; out_error out ERR_W; out_startofpacket out 1; out_endofpacket out 1; out_empty out EMPTY_W.
REQ-009 SHALL have ports: fill_level out clog2(DEPTH+1), current occupancy; ovf_flag out 1, sticky overflow; ovf_count out 16, dropped-beat count; ovf_clr in 1, clears both.

Function
REQ-010 SHALL store payload {data, error, sop, eop, empty} per beat in a DEPTH-entry circular FIFO with wrap-around read/write pointers.
REQ-011 SHALL drive in_ready = (fill_level < DEPTH - L), computed from registered fill_level only.
REQ-012 SHALL, for L=0, push when in_valid && in_ready; for L>0, push on every in_valid cycle regardless of in_ready.
REQ-013 SHALL accept a push at fill_level == DEPTH only if a pop occurs the same cycle; otherwise the beat is dropped (overflow event).
REQ-014 SHALL drive out_valid = (fill_level != 0), show-ahead; out_* payload = head entry, all zero when out_valid = 0.
REQ-015 SHALL pop on out_valid && out_ready (output ready latency 0).
REQ-016 SHALL give latency 1: a beat pushed into an empty FIFO in cycle N appears on out_valid in cycle N+1.
REQ-017 SHALL update fill_level +1 push-only, -1 pop-only, unchanged for push+pop or neither; never exceed DEPTH or underflow.
REQ-018 SHALL pass payload unmodified; no packet framing check or reordering.

Reset
REQ-019 SHALL, while reset = 1 at a clk edge, clear pointers, fill_level, ovf_flag, ovf_count; in_ready = 0, out_valid = 0, out_* payload = 0 during reset.
REQ-020 SHALL discard all stored beats on reset mid-packet; first cycle after reset in_ready = 1.
REQ-021 SHALL ignore in_valid during reset cycles.

Configuration
REQ-022 SHALL, with ST_TA_OVF_STATS_EN defined, set ovf_flag on any overflow event and increment ovf_count (saturating at 65535) per dropped beat; ovf_clr has priority over a same-cycle overflow event (result 0).
REQ-023 SHALL, with ST_TA_OVF_STATS_EN undefined, tie ovf_flag and ovf_count to 0, ignore ovf_clr, and still drop overflow beats per REQ-013.

Verification (defaults, DEPTH=8, L=3, macro defined)
REQ-024 SHALL cover: reset, push one beat 0xCAFE0001 sop=1 eop=1 empty=2, out_ready=1 -> out_valid 1 cycle later with identical payload, fill_level 1 then 0.
REQ-025 SHALL cover: out_ready=0, in_valid held -> in_ready drops when fill_level=5; 3 further beats accepted, fill_level=8, ovf_flag=0.
REQ-026 SHALL cover: full FIFO, out_ready=0, 2 extra in_valid beats -> both dropped, ovf_flag=1, ovf_count=2; ovf_clr pulse -> both 0.
REQ-027 SHALL cover: full FIFO, in_valid and out_ready both 1 for 20 cycles -> fill_level stays 8, zero drops, order preserved across pointer wrap.
REQ-028 SHALL cover: reset asserted with fill_level=4 mid-packet -> next cycle out_valid=0, fill_level=0, payload 0; L=0 build: no push while in_ready=0.

Source files
------------

// File: rtl/st_timing_adapter_ps_if.sv
// Streaming port bundle for st_timing_adapter_ps: input stream, output stream and overflow status.
// slave = adapter view, master = environment view.
interface st_timing_adapter_ps_if #(
    parameter int DATA_W  = 32,
    parameter int ERR_W   = 6,
    parameter int EMPTY_W = 2,
    parameter int DEPTH   = 8
);
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic                in_ready;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic [ERR_W-1:0]    in_error;
    logic                in_startofpacket;
    logic                in_endofpacket;
    logic [EMPTY_W-1:0]  in_empty;

    logic                out_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [ERR_W-1:0]    out_error;
    logic                out_startofpacket;
    logic                out_endofpacket;
    logic [EMPTY_W-1:0]  out_empty;

    logic [FILL_W-1:0]   fill_level;
    logic                ovf_flag;
    logic [15:0]         ovf_count;
    logic                ovf_clr;

    modport slave (
        output in_ready,
        input  in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
        input  out_ready,
        output out_valid, out_data, out_error, out_startofpacket, out_endofpacket, out_empty,
        output fill_level, ovf_flag, ovf_count,
        input  ovf_clr
    );

    modport master (
        input  in_ready,
        output in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
        output out_ready,
        input  out_valid, out_data, out_error, out_startofpacket, out_endofpacket, out_empty,
        input  fill_level, ovf_flag, ovf_count,
        output ovf_clr
    );
endinterface

// File: rtl/st_timing_adapter_ps.sv
// Streaming ready-latency adapter: converts input ready latency L (0..3) to output ready latency 0 via a DEPTH-entry FIFO.
// Latency 1 cycle (push in N, out_valid in N+1); in_ready deasserts at DEPTH-L occupancy, beats arriving at full are dropped.
// Overflow statistics (ovf_flag/ovf_count) are built only with ST_TA_OVF_STATS_EN defined.
module st_timing_adapter_ps #(
    parameter int DATA_W           = 32,
    parameter int ERR_W            = 6,
    parameter int EMPTY_W          = 2,
    parameter int DEPTH            = 8,
    parameter int IN_READY_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    st_timing_adapter_ps_if.slave   bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    localparam logic [AW-1:0]     PTR_ONE    = AW'(1);
    localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);
    localparam logic [FILL_W-1:0] FULL_LVL   = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] RDY_THRESH = FILL_W'(DEPTH - IN_READY_LATENCY);

    generate
        if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of two in 2..256");
        end
        if (IN_READY_LATENCY < 0 || IN_READY_LATENCY > 3 || DEPTH < IN_READY_LATENCY + 2) begin : g_bad_lat
            $error("IN_READY_LATENCY must be 0..3 with DEPTH >= L+2");
        end
        if (ERR_W < 1 || ERR_W > 16 || EMPTY_W < 1 || EMPTY_W > 8) begin : g_bad_side
            $error("ERR_W must be 1..16 and EMPTY_W 1..8");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [ERR_W-1:0]   error;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    beat_t              mem_q [DEPTH];
    beat_t              in_beat;
    beat_t              head_beat;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;

    logic               in_rdy;
    logic               out_vld;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               ovf_evt;

    assign in_rdy  = !reset && (fill_q < RDY_THRESH);
    assign out_vld = !reset && (fill_q != '0);
    assign pop     = out_vld && bus.out_ready;

    // With L>0 the upstream may still be sending beats it launched before in_ready fell, so in_ready is not a qualifier.
    assign push_req = !reset && bus.in_valid && ((IN_READY_LATENCY != 0) || in_rdy);
    assign push_ok  = push_req && ((fill_q != FULL_LVL) || pop);
    assign ovf_evt  = push_req && !push_ok;

    assign in_beat = '{
        data:  bus.in_data,
        error: bus.in_error,
        sop:   bus.in_startofpacket,
        eop:   bus.in_endofpacket,
        empty: bus.in_empty
    };

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage is never reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= in_beat;
        end
    end

    assign head_beat = out_vld ? mem_q[rd_ptr_q] : '0;

    assign bus.in_ready          = in_rdy;
    assign bus.out_valid         = out_vld;
    assign bus.out_data          = head_beat.data;
    assign bus.out_error         = head_beat.error;
    assign bus.out_startofpacket = head_beat.sop;
    assign bus.out_endofpacket   = head_beat.eop;
    assign bus.out_empty         = head_beat.empty;
    assign bus.fill_level        = fill_q;

`ifdef ST_TA_OVF_STATS_EN
    logic        ovf_flag_q, ovf_flag_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_flag_d = ovf_flag_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (bus.ovf_clr) begin
            ovf_flag_d = 1'b0;
            ovf_cnt_d  = '0;
        end else if (ovf_evt) begin
            ovf_flag_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            ovf_flag_q <= ovf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign bus.ovf_flag  = ovf_flag_q;
    assign bus.ovf_count = ovf_cnt_q;
`else
    logic unused_ovf;
    assign unused_ovf    = &{1'b0, ovf_evt, bus.ovf_clr};
    assign bus.ovf_flag  = 1'b0;
    assign bus.ovf_count = '0;
`endif
endmodule

// File: tb/tb_st_timing_adapter_ps.sv
// Bench for st_timing_adapter_ps: directed table, multi-cycle corner sequences, then random traffic vs a queue model.
module tb_st_timing_adapter_ps;
    localparam int DATA_W  = 32;
    localparam int ERR_W   = 6;
    localparam int EMPTY_W = 2;
    localparam int DEPTH   = 8;
    localparam int L       = 3;
`ifdef ST_TA_OVF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    st_timing_adapter_ps_if #(.DATA_W(DATA_W), .ERR_W(ERR_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH)) bus ();

    st_timing_adapter_ps #(
        .DATA_W(DATA_W), .ERR_W(ERR_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH), .IN_READY_LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  err;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } mbeat_t;

    typedef struct {
        bit rst, iv, ordy, clr;
        int fill;
        bit ir, ov, flag;
        int cnt;
    } vec_t;

    mbeat_t mq[$];
    bit     m_flag;
    int     m_cnt;
    int     n_chk = 0;
    int     n_fail = 0;

    bit     cur_rst, cur_iv, cur_ordy, cur_clr;
    vec_t   tbl[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mbeat_t rand_beat();
        mbeat_t b;
        b.data  = $urandom;
        b.err   = 6'($urandom_range(0, 63));
        b.sop   = 1'($urandom_range(0, 1));
        b.eop   = 1'($urandom_range(0, 1));
        b.empty = 2'($urandom_range(0, 3));
        return b;
    endfunction

    task automatic drive(input bit rst, input bit iv, input bit ordy, input bit clr, input mbeat_t b);
        cur_rst  = rst;
        cur_iv   = iv;
        cur_ordy = ordy;
        cur_clr  = clr;
        reset                = rst;
        bus.in_valid         = iv;
        bus.in_data          = b.data;
        bus.in_error         = b.err;
        bus.in_startofpacket = b.sop;
        bus.in_endofpacket   = b.eop;
        bus.in_empty         = b.empty;
        bus.out_ready        = ordy;
        bus.ovf_clr          = clr;
    endtask

    // Compare the DUT against the queue model for the current cycle, then advance the model past the clock edge.
    task automatic model_cycle(input mbeat_t b);
        bit     e_ir, e_ov, pop, push;
        mbeat_t head;
        e_ir = !cur_rst && (mq.size() < DEPTH - L);
        e_ov = !cur_rst && (mq.size() != 0);
        head = e_ov ? mq[0] : '0;
        chk("in_ready",   bus.in_ready, e_ir);
        chk("out_valid",  bus.out_valid, e_ov);
        chk("fill_level", bus.fill_level, mq.size());
        chk("out_data",   bus.out_data, head.data);
        chk("out_error",  bus.out_error, head.err);
        chk("out_sop",    bus.out_startofpacket, head.sop);
        chk("out_eop",    bus.out_endofpacket, head.eop);
        chk("out_empty",  bus.out_empty, head.empty);
        chk("ovf_flag",   bus.ovf_flag, STATS ? m_flag : 1'b0);
        chk("ovf_count",  bus.ovf_count, STATS ? m_cnt : 0);
        if (cur_rst) begin
            mq.delete();
            m_flag = 1'b0;
            m_cnt  = 0;
        end else begin
            bit drop;
            drop = 1'b0;
            pop  = e_ov && cur_ordy;
            push = cur_iv && (L != 0 || e_ir);
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(b);
                else drop = 1'b1;
            end
            if (cur_clr) begin
                m_flag = 1'b0;
                m_cnt  = 0;
            end else if (drop) begin
                m_flag = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    task automatic run_cycle(input bit rst, input bit iv, input bit ordy, input bit clr, input mbeat_t b);
        drive(rst, iv, ordy, clr, b);
        @(negedge clk);
        model_cycle(b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        mbeat_t b;
        m_flag = 1'b0;
        m_cnt  = 0;

        // rst iv ordy clr | fill ir ov flag cnt  (outputs observed before the clock edge)
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 2, 1, 1, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 3, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 4, 1, 1, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 5, 0, 1, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 6, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 7, 0, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 8, 0, 1, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 8, 0, 1, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 8, 0, 1, 1, 1};
        tbl[15] = '{0, 0, 0, 0, 8, 0, 1, 1, 2};
        tbl[16] = '{0, 0, 0, 1, 8, 0, 1, 1, 2};
        tbl[17] = '{0, 0, 0, 0, 8, 0, 1, 0, 0};
        tbl[18] = '{0, 1, 0, 1, 8, 0, 1, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 8, 0, 1, 0, 0};

        b = '0;
        drive(1, 0, 0, 0, b);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            if (i == 1) b = '{data: 32'hCAFE0001, err: 6'd0, sop: 1'b1, eop: 1'b1, empty: 2'd2};
            else b = '{data: 32'hA000_0000 + 32'(i), err: 6'(i), sop: 1'(i == 4), eop: 1'(i == 11), empty: 2'(i)};
            drive(tbl[i].rst, tbl[i].iv, tbl[i].ordy, tbl[i].clr, b);
            @(negedge clk);
            chk($sformatf("vec%0d_fill", i), bus.fill_level, tbl[i].fill);
            chk($sformatf("vec%0d_in_ready", i), bus.in_ready, tbl[i].ir);
            chk($sformatf("vec%0d_out_valid", i), bus.out_valid, tbl[i].ov);
            chk($sformatf("vec%0d_ovf_flag", i), bus.ovf_flag, STATS ? tbl[i].flag : 1'b0);
            chk($sformatf("vec%0d_ovf_count", i), bus.ovf_count, STATS ? tbl[i].cnt : 0);
            if (i == 2) begin
                chk("first_beat_data", bus.out_data, 32'hCAFE0001);
                chk("first_beat_sop_eop", {bus.out_startofpacket, bus.out_endofpacket}, 2'b11);
                chk("first_beat_empty", bus.out_empty, 2'd2);
            end
            model_cycle(b);
            @(posedge clk);
            #1;
        end

        // Full FIFO streaming through with push and pop every cycle, wrapping the pointers.
        for (int i = 0; i < 20; i++) begin
            b = rand_beat();
            drive(0, 1, 1, 0, b);
            @(negedge clk);
            chk("wrap_fill", bus.fill_level, DEPTH);
            model_cycle(b);
            @(posedge clk);
            #1;
        end
        chk("wrap_no_drops", bus.ovf_count, 0);

        // Drain to half full, then reset in the middle of a packet.
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 1, 0, rand_beat());
        chk("pre_reset_fill", bus.fill_level, 4);
        b = rand_beat();
        drive(1, 1, 1, 0, b);
        @(negedge clk);
        chk("in_reset_out_valid", bus.out_valid, 1'b0);
        chk("in_reset_in_ready", bus.in_ready, 1'b0);
        chk("in_reset_out_data", bus.out_data, 32'h0);
        model_cycle(b);
        @(posedge clk);
        #1;
        b = rand_beat();
        drive(0, 0, 0, 0, b);
        @(negedge clk);
        chk("post_reset_fill", bus.fill_level, 0);
        chk("post_reset_out_valid", bus.out_valid, 1'b0);
        chk("post_reset_payload", {bus.out_data, bus.out_error, bus.out_startofpacket, bus.out_endofpacket, bus.out_empty}, 0);
        chk("post_reset_in_ready", bus.in_ready, 1'b1);
        model_cycle(b);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_iv, r_ordy, r_clr;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_iv   = ($urandom_range(0, 9) < 7);
            r_ordy = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 8));
            r_clr  = ($urandom_range(0, 49) == 0);
            run_cycle(r_rst, r_iv, r_ordy, r_clr, rand_beat());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
